vga_timing_out: RTL and testbench



---
 rtl/vga_timing_out_if.sv | 25 ++
 rtl/vga_timing_out.sv | 77 +++++++
 tb/tb_vga_timing_out.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_timing_out_if.sv
// vga_timing_out_if: pixel bus (pix_en, RGB_in, pixel_x/y, in_display, start_of_frame) and VGA DAC pins
interface vga_timing_out_if;
  logic        pix_en;
  logic [7:0]  RGB_in;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        in_display;
  logic        start_of_frame;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank;
  modport master (
    input  pix_en, RGB_in,
    output pixel_x, pixel_y, in_display, start_of_frame,
           vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank
  );
  modport slave (
    output pix_en, RGB_in,
    input  pixel_x, pixel_y, in_display, start_of_frame,
           vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank
  );
endinterface

// File: rtl/vga_timing_out.sv
// vga_timing_out: raster counters, sync/blank delay line and 4-4-4 DAC output stage; ports clk, reset, vif (master)
module vga_timing_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 1
) (
  input logic clk,
  input logic reset,
  vga_timing_out_if.master vif
);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HSS = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VSS = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSE = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [2:0]  IDLE = {!SYNC_POL, !SYNC_POL, 1'b0};
  logic [10:0] h, v;
  logic h_end, v_end;
  logic [2:0] raw, tail;
  assign h_end = h == HL;
  assign v_end = v == VL;
  assign raw = {(h >= HSS && h < HSE) ? SYNC_POL : !SYNC_POL,
                (v >= VSS && v < VSE) ? SYNC_POL : !SYNC_POL,
                h < HA && v < VA};
  assign vif.pixel_x = h;
  assign vif.pixel_y = v;
  assign vif.in_display = raw[0];
  generate
    if (PIPE_LAT <= 1) begin : g_direct
      assign tail = raw;
    end else begin : g_pipe
      logic [2:0] dl [PIPE_LAT-1];
      always_ff @(posedge clk)
        if (reset)
          for (int i = 0; i < PIPE_LAT - 1; i++) dl[i] <= IDLE;
        else if (vif.pix_en) begin
          dl[0] <= raw;
          for (int i = 1; i < PIPE_LAT - 1; i++) dl[i] <= dl[i-1];
        end
      assign tail = dl[PIPE_LAT-2];
    end
  endgenerate
  always_ff @(posedge clk)
    if (reset) begin
      h <= '0;
      v <= '0;
      vif.start_of_frame <= 1'b0;
      vif.vga_hs <= !SYNC_POL;
      vif.vga_vs <= !SYNC_POL;
      vif.vga_blank <= 1'b1;
      vif.vga_r <= '0;
      vif.vga_g <= '0;
      vif.vga_b <= '0;
    end else begin
      vif.start_of_frame <= vif.pix_en && h_end && v_end;
      if (vif.pix_en) begin
        h <= h_end ? '0 : h + 11'd1;
        if (h_end) v <= v_end ? '0 : v + 11'd1;
        vif.vga_hs <= tail[2];
        vif.vga_vs <= tail[1];
        vif.vga_blank <= !tail[0];
        vif.vga_r <= tail[0] ? {vif.RGB_in[7:5], vif.RGB_in[7]} : 4'd0;
        vif.vga_g <= tail[0] ? {vif.RGB_in[4:2], vif.RGB_in[4]} : 4'd0;
        vif.vga_b <= tail[0] ? {vif.RGB_in[1:0], vif.RGB_in[1:0]} : 4'd0;
      end
    end
endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: scoreboard bench; default horizontal timing, vertical shrunk to 10 lines so frames fit the run
module tb_vga_timing_out;
  localparam int PX = 0, PY = 1, IND = 2, SOF = 3, HS = 4, VS = 5, BLK = 6, RGB = 7;
  typedef struct {int ep; int tick; int dly; int sel; logic [31:0] val;} exp_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  vga_timing_out_if vif();
  vga_timing_out #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (.clk(clk), .reset(reset), .vif(vif));
  exp_t q[$];
  int tcnt = 0, epoch = 0, age = 0, checks = 0, errors = 0;
  bit in_rst = 0;
  string names[8] = '{"pixel_x", "pixel_y", "in_display", "start_of_frame", "vga_hs", "vga_vs", "vga_blank", "rgb"};
  always @(posedge clk)
    if (reset) begin
      tcnt <= 0;
      age <= 0;
      if (!in_rst) epoch <= epoch + 1;
      in_rst <= 1;
    end else begin
      in_rst <= 0;
      age <= vif.pix_en ? 0 : age + 1;
      if (vif.pix_en) tcnt <= tcnt + 1;
    end
  function automatic logic [31:0] act(int s);
    case (s)
      PX:  return 32'(vif.pixel_x);
      PY:  return 32'(vif.pixel_y);
      IND: return 32'(vif.in_display);
      SOF: return 32'(vif.start_of_frame);
      HS:  return 32'(vif.vga_hs);
      VS:  return 32'(vif.vga_vs);
      BLK: return 32'(vif.vga_blank);
      default: return {20'd0, vif.vga_r, vif.vga_g, vif.vga_b};
    endcase
  endfunction
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (q.size() > 0) begin
      e = q[0];
      if (e.ep == epoch && e.tick == tcnt && e.dly == age) begin
        checks++;
        a = act(e.sel);
        if (a !== e.val) begin
          errors++;
          $display("FAIL %s ep%0d tick%0d+%0d: got %0h expected %0h", names[e.sel], e.ep, e.tick, e.dly, a, e.val);
        end
        void'(q.pop_front());
      end else if (e.ep < epoch || (e.ep == epoch && (e.tick < tcnt || (e.tick == tcnt && e.dly < age)))) begin
        checks++;
        errors++;
        $display("FAIL %s ep%0d tick%0d+%0d: never sampled, expected %0h", names[e.sel], e.ep, e.tick, e.dly, e.val);
        void'(q.pop_front());
      end else break;
    end
  end
  task automatic ex(int ep, int tick, int dly, int sel, logic [31:0] val);
    q.push_back('{ep, tick, dly, sel, val});
  endtask
  task automatic rst_vals(int ep);
    ex(ep, 0, 0, PX, 0); ex(ep, 0, 0, PY, 0); ex(ep, 0, 0, IND, 1); ex(ep, 0, 0, SOF, 0);
    ex(ep, 0, 0, HS, 1); ex(ep, 0, 0, VS, 1); ex(ep, 0, 0, BLK, 1); ex(ep, 0, 0, RGB, 0);
  endtask
  task automatic tk(logic [7:0] c);
    @(negedge clk);
    vif.RGB_in = c;
    vif.pix_en = 1;
    @(negedge clk);
    vif.pix_en = 0;
  endtask
  function automatic logic [7:0] col(int i);
    return i <= 100 ? 8'hFC : i <= 200 ? 8'h03 : i <= 689 ? 8'hE0 : 8'hFF;
  endfunction
  initial begin
    vif.pix_en = 0;
    vif.RGB_in = 0;
    rst_vals(1);
    ex(1, 1, 0, PX, 1); ex(1, 1, 0, PY, 0); ex(1, 1, 0, HS, 1); ex(1, 1, 0, BLK, 0); ex(1, 1, 0, RGB, 12'hFF0);
    ex(1, 50, 0, RGB, 12'hFF0);
    ex(1, 150, 0, RGB, 12'h00F);
    ex(1, 250, 0, RGB, 12'hF00);
    ex(1, 640, 0, PX, 640); ex(1, 640, 0, IND, 0); ex(1, 640, 0, BLK, 0); ex(1, 640, 0, RGB, 12'hF00);
    ex(1, 641, 0, BLK, 1); ex(1, 641, 0, RGB, 0);
    ex(1, 656, 0, PX, 656); ex(1, 656, 0, HS, 1);
    ex(1, 657, 0, HS, 0);
    ex(1, 701, 0, RGB, 0); ex(1, 701, 0, BLK, 1);
    ex(1, 752, 0, HS, 0);
    ex(1, 753, 0, HS, 1);
    ex(1, 799, 0, PX, 799); ex(1, 799, 0, PY, 0); ex(1, 799, 0, IND, 0);
    ex(1, 800, 0, PX, 0); ex(1, 800, 0, PY, 1); ex(1, 800, 0, IND, 1); ex(1, 800, 0, SOF, 0);
    ex(1, 801, 0, BLK, 0); ex(1, 801, 0, RGB, 12'hFFF); ex(1, 801, 0, HS, 1);
    ex(1, 3000, 0, IND, 1);
    ex(1, 3200, 0, IND, 0); ex(1, 3200, 0, PY, 4); ex(1, 3200, 0, PX, 0);
    ex(1, 4800, 0, VS, 1); ex(1, 4800, 0, PY, 6);
    ex(1, 4801, 0, VS, 0);
    ex(1, 6400, 0, VS, 0); ex(1, 6400, 0, PY, 8);
    ex(1, 6401, 0, VS, 1);
    ex(1, 7999, 0, PX, 799); ex(1, 7999, 0, PY, 9); ex(1, 7999, 0, SOF, 0);
    ex(1, 8000, 0, PX, 0); ex(1, 8000, 0, PY, 0); ex(1, 8000, 0, SOF, 1); ex(1, 8000, 0, IND, 1);
    ex(1, 8000, 1, SOF, 0);
    ex(1, 8300, 0, PX, 300); ex(1, 8300, 0, PY, 0); ex(1, 8300, 0, RGB, 12'hFFF); ex(1, 8300, 0, BLK, 0);
    ex(1, 8300, 50, PX, 300); ex(1, 8300, 50, PY, 0); ex(1, 8300, 50, RGB, 12'hFFF);
    ex(1, 8300, 50, BLK, 0); ex(1, 8300, 50, HS, 1); ex(1, 8300, 50, SOF, 0);
    ex(1, 8301, 0, PX, 301); ex(1, 8301, 0, PY, 0);
    ex(1, 16000, 0, PX, 0); ex(1, 16000, 0, PY, 0); ex(1, 16000, 0, SOF, 1);
    ex(1, 16000, 1, SOF, 0);
    ex(1, 17900, 0, PX, 300); ex(1, 17900, 0, PY, 2); ex(1, 17900, 0, BLK, 0);
    repeat (3) @(negedge clk) vif.pix_en = ~vif.pix_en;
    reset = 0;
    vif.pix_en = 0;
    for (int i = 1; i <= 17900; i++) begin
      tk(col(i));
      if (i == 8300) begin
        vif.RGB_in = 8'h00;
        repeat (49) @(negedge clk);
      end
    end
    rst_vals(2);
    ex(2, 1, 0, PX, 1); ex(2, 1, 0, PY, 0);
    ex(2, 641, 0, BLK, 1);
    ex(2, 656, 0, HS, 1);
    ex(2, 657, 0, HS, 0);
    ex(2, 752, 0, HS, 0);
    ex(2, 753, 0, HS, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 1; i <= 760; i++) tk(8'hFC);
    repeat (4) @(negedge clk);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s ep%0d tick%0d: left unchecked, expected %0h", names[q[0].sel], q[0].ep, q[0].tick, q[0].val);
      void'(q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
